// File: rtl/noc_port_mux2.sv
// Two-input flit multiplexer for the NoC router output stage.
// A one-hot select picks port 0 or port 1; any other select code parks the
// output idle (all zero). Outputs are registered: one cycle of latency.
module noc_port_mux2 #(
  parameter int unsigned DATA_W = 66,
  parameter int unsigned VCH_W  = 2,
  parameter int unsigned SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] idata_0,
  input  logic              ivalid_0,
  input  logic [VCH_W-1:0]  ivch_0,
  input  logic [DATA_W-1:0] idata_1,
  input  logic              ivalid_1,
  input  logic [VCH_W-1:0]  ivch_1,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic [VCH_W-1:0]  ovch
);

  // Only these two exact codes select a source; the full width is compared so
  // multi-hot codes and unused upper bits fall through to idle.
  localparam logic [SEL_W-1:0] SelPort0 = SEL_W'(1);
  localparam logic [SEL_W-1:0] SelPort1 = SEL_W'(2);

  logic [DATA_W-1:0] odata_d, odata_q;
  logic              ovalid_d, ovalid_q;
  logic [VCH_W-1:0]  ovch_d, ovch_q;

  // Decode the select and steer the chosen port; data is not gated by valid.
  always_comb begin
    odata_d  = '0;
    ovalid_d = 1'b0;
    ovch_d   = '0;
    case (sel)
      SelPort0: begin
        odata_d  = idata_0;
        ovalid_d = ivalid_0;
        ovch_d   = ivch_0;
      end
      SelPort1: begin
        odata_d  = idata_1;
        ovalid_d = ivalid_1;
        ovch_d   = ivch_1;
      end
      default: begin
        odata_d  = '0;
        ovalid_d = 1'b0;
        ovch_d   = '0;
      end
    endcase
  end

  // Output register; every edge overwrites, reset clears without a clock.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
    end else begin
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovch_q   <= ovch_d;
    end
  end

  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign ovch   = ovch_q;

endmodule

// File: tb/tb_noc_port_mux2.sv
// Self-checking bench for noc_port_mux2: a vector table plus hand-written
// sequences, with expected outputs queued at drive time and popped one edge later.
module tb_noc_port_mux2;

  localparam int unsigned DATA_W = 66;
  localparam int unsigned VCH_W  = 2;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned OUT_W  = DATA_W + 1 + VCH_W;

  localparam logic [1:0] THead = 2'd0;
  localparam logic [1:0] TData = 2'd1;
  localparam logic [1:0] TTail = 2'd2;

  logic              clk;
  logic              rst_;
  logic [DATA_W-1:0] idata_0, idata_1;
  logic              ivalid_0, ivalid_1;
  logic [VCH_W-1:0]  ivch_0, ivch_1;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [VCH_W-1:0]  ovch;

  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] exp_q[$];

  noc_port_mux2 #(
    .DATA_W(DATA_W),
    .VCH_W (VCH_W),
    .SEL_W (SEL_W)
  ) dut (
    .clk     (clk),
    .rst_    (rst_),
    .idata_0 (idata_0),
    .ivalid_0(ivalid_0),
    .ivch_0  (ivch_0),
    .idata_1 (idata_1),
    .ivalid_1(ivalid_1),
    .ivch_1  (ivch_1),
    .sel     (sel),
    .odata   (odata),
    .ovalid  (ovalid),
    .ovch    (ovch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string             name;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] d0;
    logic              v0;
    logic [VCH_W-1:0]  c0;
    logic [DATA_W-1:0] d1;
    logic              v1;
    logic [VCH_W-1:0]  c1;
    logic [DATA_W-1:0] ed;
    logic              ev;
    logic [VCH_W-1:0]  ec;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [OUT_W-1:0] got,
                       input logic [OUT_W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference behaviour of the mux for the currently driven inputs.
  function automatic logic [OUT_W-1:0] model();
    if (sel == 5'b00001) return {idata_0, ivalid_0, ivch_0};
    if (sel == 5'b00010) return {idata_1, ivalid_1, ivch_1};
    return '0;
  endfunction

  // Queue the expectation for the driven inputs, take one edge, compare.
  task automatic step(input string name);
    exp_q.push_back(model());
    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got empty-queue want entry", name);
    end else begin
      logic [OUT_W-1:0] e;
      e = exp_q.pop_front();
      total--;
      check(name, {odata, ovalid, ovch}, e);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data(input logic [1:0] t);
    return {t, $urandom(), $urandom()};
  endfunction

  task automatic rnd_port0();
    idata_0  = rnd_data(2'($urandom_range(0, 3)));
    ivalid_0 = 1'($urandom_range(0, 1));
    ivch_0   = 2'($urandom_range(0, 3));
  endtask

  initial begin
    logic [41:0] pats[3];
    pats[0] = 42'h0;
    pats[1] = 42'h3FFFFC00000;
    pats[2] = 42'h3FFFFFFFFFC;

    // Vector table: {sel, port0, port1} -> expected outputs.
    vecs[0] = '{"p1_head", 5'b00010, {TData, 64'hAAAA}, 1'b1, 2'd3,
                {THead, 32'h0, 32'h04}, 1'b1, 2'd1, {THead, 32'h0, 32'h04}, 1'b1, 2'd1};
    vecs[1] = '{"p1_head_p0tog", 5'b00010, {TTail, 64'h5555}, 1'b0, 2'd2,
                {THead, 32'h0, 32'h04}, 1'b1, 2'd1, {THead, 32'h0, 32'h04}, 1'b1, 2'd1};
    vecs[2] = '{"p0_data", 5'b00001, {TData, 64'h0123456789ABCDEF}, 1'b1, 2'd2,
                {TData, 64'hFFFF}, 1'b1, 2'd1, {TData, 64'h0123456789ABCDEF}, 1'b1, 2'd2};
    vecs[3] = '{"p0_novalid", 5'b00001, {TTail, 64'hDEAD}, 1'b0, 2'd3,
                {TData, 64'h1}, 1'b1, 2'd0, {TTail, 64'hDEAD}, 1'b0, 2'd3};
    vecs[4] = '{"idle_00000", 5'b00000, {TData, 64'h11}, 1'b1, 2'd1,
                {TData, 64'h22}, 1'b1, 2'd2, '0, 1'b0, '0};
    vecs[5] = '{"idle_00011", 5'b00011, {TData, 64'h33}, 1'b1, 2'd3,
                {TData, 64'h44}, 1'b1, 2'd2, '0, 1'b0, '0};
    vecs[6] = '{"idle_00100", 5'b00100, {TData, 64'h55}, 1'b1, 2'd1,
                {TData, 64'h66}, 1'b1, 2'd3, '0, 1'b0, '0};
    vecs[7] = '{"idle_10001", 5'b10001, {TData, 64'h77}, 1'b1, 2'd1,
                {TData, 64'h88}, 1'b1, 2'd3, '0, 1'b0, '0};
    vecs[8] = '{"idle_10010", 5'b10010, {TData, 64'h99}, 1'b1, 2'd1,
                {TData, 64'hAA}, 1'b1, 2'd3, '0, 1'b0, '0};

    // Reset held with random inputs and port 1 selected.
    rst_ = 1'b0;
    sel  = 5'b00010;
    rnd_port0();
    idata_1  = rnd_data(THead);
    ivalid_1 = 1'b1;
    ivch_1   = 2'd2;
    #1;
    check("reset_async", {odata, ovalid, ovch}, '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", {odata, ovalid, ovch}, '0);
    #2;
    rst_ = 1'b1;
    #1;
    check("reset_release_noedge", {odata, ovalid, ovch}, '0);

    // Table-driven vectors; each row is independent of the previous output.
    for (int i = 0; i < 9; i++) begin
      sel      = vecs[i].sel;
      idata_0  = vecs[i].d0;
      ivalid_0 = vecs[i].v0;
      ivch_0   = vecs[i].c0;
      idata_1  = vecs[i].d1;
      ivalid_1 = vecs[i].v1;
      ivch_1   = vecs[i].c1;
      @(posedge clk);
      #1;
      check(vecs[i].name, {odata, ovalid, ovch}, {vecs[i].ed, vecs[i].ev, vecs[i].ec});
    end

    // Port-1 path with port 0 randomly toggling.
    sel      = 5'b00010;
    idata_1  = {THead, 32'h0, 32'h04};
    ivalid_1 = 1'b1;
    ivch_1   = 2'd1;
    for (int i = 0; i < 4; i++) begin
      rnd_port0();
      step("p1_p0toggle");
    end

    // Port-0 stream: 20 DATA flits, a TAIL, then valid drops.
    sel = 5'b00001;
    for (int i = 0; i < 21; i++) begin
      idata_0  = rnd_data(i == 20 ? TTail : TData);
      ivalid_0 = 1'b1;
      ivch_0   = 2'd2;
      idata_1  = rnd_data(TData);
      ivalid_1 = 1'($urandom_range(0, 1));
      step("p0_stream");
    end
    ivalid_0 = 1'b0;
    step("p0_valid_fall");
    check("p0_ovalid_low", {31'b0, ovalid}, 32'd0);

    // Mid-stream switch from port 1 to port 0 between two flits.
    sel      = 5'b00010;
    idata_1  = {THead, 64'h1111_2222_3333_4444};
    ivalid_1 = 1'b1;
    ivch_1   = 2'd3;
    idata_0  = {TData, 64'h5555_6666_7777_8888};
    ivalid_0 = 1'b1;
    ivch_0   = 2'd0;
    step("switch_before");
    sel = 5'b00001;
    idata_1 = {TData, 64'h9999};
    @(posedge clk);
    #1;
    check("switch_after", {odata, ovalid, ovch}, {TData, 64'h5555_6666_7777_8888, 1'b1, 2'd0});

    // Reset asserted mid-packet clears outputs without an edge.
    #2;
    rst_ = 1'b0;
    #1;
    check("reset_midpkt", {odata, ovalid, ovch}, '0);
    @(posedge clk);
    #1;
    check("reset_midpkt_held", {odata, ovalid, ovch}, '0);
    rst_ = 1'b1;
    step("post_reset_first");

    // Toggle stress on port 1: 10 packets of 20 flits, 7 idle cycles between.
    sel = 5'b00010;
    for (int p = 0; p < 10; p++) begin
      for (int f = 0; f < 20; f++) begin
        idata_1  = {(f == 0) ? THead : ((f == 19) ? TTail : TData), 22'h0, pats[(p + f) % 3]};
        ivalid_1 = 1'b1;
        ivch_1   = 2'(p);
        rnd_port0();
        step("stress_flit");
      end
      for (int k = 0; k < 7; k++) begin
        ivalid_1 = 1'b0;
        idata_1  = '0;
        step("stress_idle");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
